// File: rtl/pcpu_mem_pkg.sv
// Shared encodings for the PCPU MEM-stage access unit: size codes, FSM states,
// byte-enable patterns and the latched request record.
package pcpu_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Reserved size is treated as an alignment fault so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: replicates store data across byte lanes with the
// matching byte enables, and extracts/extends load data from the bus word.
module mem_lane_align
    import pcpu_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_bus,
    output logic [31:0] data_out,
    output logic [3:0]  byte_en,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = rdata_bus >> {addr_lo, 3'b000};
        half_sel = addr_lo[1] ? rdata_bus[31:16] : rdata_bus[15:0];
        data_out = wdata;
        byte_en  = BE_WORD;
        rdata    = rdata_bus;
        case (size)
            SIZE_BYTE: begin
                data_out = {4{wdata[7:0]}};
                byte_en  = BE_BYTE0 << addr_lo;
                rdata    = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                data_out = {2{wdata[15:0]}};
                byte_en  = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                rdata    = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: IDLE/BUSY/DONE handshake on the MIO
// bus with pipeline stall, timeout abort and registered one-cycle response.
module mem_access_unit
    import pcpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        align_err,
    output logic        bus_err,
    output logic        CPU_MIO,
    output logic        mem_w,
    output logic [31:0] data_addr,
    output logic [31:0] data_out,
    output logic [3:0]  byte_en,
    input  logic        MIO_ready,
    input  logic [31:0] data_mem
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_reg, state_next;
    mem_req_t      req_reg, req_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          align_err_reg, align_err_next;
    logic          bus_err_reg, bus_err_next;

    logic          busy;
    logic [31:0]   lane_data_out;
    logic [3:0]    lane_byte_en;
    logic [31:0]   lane_rdata;

    assign busy = (state_reg == ST_BUSY);

    mem_lane_align u_align (
        .size      (req_reg.size),
        .addr_lo   (req_reg.addr[1:0]),
        .sext      (req_reg.sext),
        .wdata     (req_reg.wdata),
        .rdata_bus (data_mem),
        .data_out  (lane_data_out),
        .byte_en   (lane_byte_en),
        .rdata     (lane_rdata)
    );

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        cnt_next       = cnt_reg;
        rdata_next     = rdata_reg;
        align_err_next = align_err_reg;
        bus_err_next   = bus_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_next     = ST_DONE;
                        align_err_next = 1'b1;
                    end else begin
                        state_next = ST_BUSY;
                        cnt_next   = '0;
                        req_next   = '{we: req_we, size: req_size, sext: req_sext,
                                       addr: req_addr, wdata: req_wdata};
                    end
                end
            end
            ST_BUSY: begin
                if (MIO_ready) begin
                    state_next = ST_DONE;
                    rdata_next = req_reg.we ? 32'h0 : lane_rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = ST_DONE;
                    bus_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                // Response fields live for exactly the DONE cycle.
                state_next     = ST_IDLE;
                rdata_next     = 32'h0;
                align_err_next = 1'b0;
                bus_err_next   = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            req_reg       <= '0;
            cnt_reg       <= '0;
            rdata_reg     <= 32'h0;
            align_err_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            cnt_reg       <= cnt_next;
            rdata_reg     <= rdata_next;
            align_err_reg <= align_err_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    // rst gates stall so the pipeline is released the moment reset asserts.
    assign stall     = rst & (busy | ((state_reg == ST_IDLE) & req_valid));
    assign rsp_valid = (state_reg == ST_DONE);
    assign rsp_rdata = rdata_reg;
    assign align_err = align_err_reg;
    assign bus_err   = bus_err_reg;
    assign CPU_MIO   = busy;
    assign mem_w     = busy & req_reg.we;
    assign data_addr = busy ? {req_reg.addr[31:2], 2'b00} : 32'h0;
    assign data_out  = busy ? lane_data_out : 32'h0;
    assign byte_en   = busy ? lane_byte_en : 4'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected responses into a
// queue, an independent monitor pops and compares on every rsp_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, align_err, bus_err;
    logic [31:0] rsp_rdata;
    logic        CPU_MIO, mem_w;
    logic [31:0] data_addr, data_out;
    logic [3:0]  byte_en;
    logic        MIO_ready;
    logic [31:0] data_mem;

    typedef struct {
        logic [31:0] rdata;
        logic        ae;
        logic        be;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .align_err(align_err), .bus_err(bus_err),
        .CPU_MIO(CPU_MIO), .mem_w(mem_w), .data_addr(data_addr),
        .data_out(data_out), .byte_en(byte_en),
        .MIO_ready(MIO_ready), .data_mem(data_mem)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_align_err", {31'h0, align_err}, {31'h0, e.ae});
                check("rsp_bus_err", {31'h0, bus_err}, {31'h0, e.be});
            end
        end
    end

    // Issue one request; rdy_at = BUSY cycle index at which MIO_ready pulses (0 = never).
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                          input int rdy_at, input logic [31:0] bus_data,
                          input logic [31:0] e_rdata, input logic e_ae, input logic e_be,
                          input int e_stall, input int e_busy,
                          input logic [31:0] e_addr, input logic [31:0] e_dout,
                          input logic [3:0] e_lanes);
        int n_stall = 0;
        int n_busy  = 0;
        bit done    = 0;
        logic [31:0] snap_dout = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wdata = wdata;
        exp_q.push_back('{rdata: e_rdata, ae: e_ae, be: e_be});
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (rsp_valid) begin
                check({tag, "_mio_done"}, {31'h0, CPU_MIO}, 32'h0);
                req_valid = 1'b0;
                MIO_ready = 1'b0;
                done = 1;
            end else if (CPU_MIO) begin
                n_busy++;
                if (n_busy == 1) begin
                    check({tag, "_data_addr"}, data_addr, e_addr);
                    check({tag, "_byte_en"}, {28'h0, byte_en}, {28'h0, e_lanes});
                    check({tag, "_mem_w"}, {31'h0, mem_w}, {31'h0, we});
                    check({tag, "_data_out"}, data_out, e_dout);
                    snap_dout = data_out;
                    req_addr  = ~addr;
                    req_wdata = ~wdata;
                end else begin
                    check({tag, "_bus_stable"}, data_out, snap_dout);
                end
                MIO_ready = (n_busy == rdy_at);
                data_mem  = (n_busy == rdy_at) ? bus_data : 32'hA5A5_A5A5;
            end
        end
        if (!done) begin
            check({tag, "_rsp_timeout"}, 32'd1, 32'd0);
            req_valid = 1'b0;
            MIO_ready = 1'b0;
        end
        check({tag, "_stall_cycles"}, n_stall, e_stall);
        check({tag, "_busy_cycles"}, n_busy, e_busy);
        $display("txn %s done: stall=%0d busy=%0d", tag, n_stall, n_busy);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_sext = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h1111_1111; MIO_ready = 1'b1; data_mem = 32'h0;
        @(negedge clk); @(negedge clk);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_mio", {31'h0, CPU_MIO}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_byte_en", {28'h0, byte_en}, 32'h0);
        check("reset_data_addr", data_addr, 32'h0);
        req_valid = 1'b0; MIO_ready = 1'b0;
        @(negedge clk); rst = 1'b1;

        do_req("st_word",   1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0,
               32'h0, 0, 0, 3, 2, 32'h100, 32'hDEADBEEF, 4'b1111);
        do_req("ld_byte_s", 0, 2'b00, 1, 32'h203, 32'h0, 1, 32'h8012_3456,
               32'hFFFF_FF80, 0, 0, 2, 1, 32'h200, 32'h0, 4'b1000);
        do_req("ld_byte_z", 0, 2'b00, 0, 32'h203, 32'h0, 1, 32'h8012_3456,
               32'h0000_0080, 0, 0, 2, 1, 32'h200, 32'h0, 4'b1000);
        do_req("st_half",   1, 2'b01, 0, 32'h002, 32'hABCD_1234, 1, 32'h0,
               32'h0, 0, 0, 2, 1, 32'h000, 32'h1234_1234, 4'b1100);
        do_req("ld_w_mis",  0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h0,
               32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 4'b0000);
        do_req("ld_w_tmo",  0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h0,
               32'h0, 0, 1, 5, 4, 32'h400, 32'h0, 4'b1111);
        do_req("ld_half_s", 0, 2'b01, 1, 32'h006, 32'h0, 1, 32'h8001_7FFF,
               32'hFFFF_8001, 0, 0, 2, 1, 32'h004, 32'h0, 4'b1100);
        do_req("rsvd_size", 0, 2'b11, 0, 32'h010, 32'h0, 1, 32'h0,
               32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 4'b0000);
        do_req("st_byte",   1, 2'b00, 0, 32'h001, 32'h0000_005A, 1, 32'h0,
               32'h0, 0, 0, 2, 1, 32'h000, 32'h5A5A_5A5A, 4'b0010);
        do_req("ld_word",   0, 2'b10, 0, 32'h010, 32'h0, 3, 32'hCAFE_F00D,
               32'hCAFE_F00D, 0, 0, 4, 3, 32'h010, 32'h0, 4'b1111);
        do_req("ld_h_mis",  0, 2'b01, 1, 32'h001, 32'h0, 1, 32'h0,
               32'h0, 1, 0, 1, 0, 32'h0, 32'h0, 4'b0000);

        // Reset in the middle of a bus cycle: abandoned, no response expected.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sext = 1'b0;
        req_addr = 32'h300; req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        check("rstmid_mio_before", {31'h0, CPU_MIO}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rstmid_mio", {31'h0, CPU_MIO}, 32'h0);
        check("rstmid_stall", {31'h0, stall}, 32'h0);
        check("rstmid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        $display("txn rst_mid_busy done");
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;

        do_req("after_rst", 0, 2'b10, 0, 32'h300, 32'h0, 1, 32'h1357_9BDF,
               32'h1357_9BDF, 0, 0, 2, 1, 32'h300, 32'h0, 4'b1111);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
